// File: rtl/sobel_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | sobel_pkg                                                          |
// | Shared types and helpers for the Sobel scan sequencer.             |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
package sobel_pkg;

    localparam int PIX_W    = 8;
    localparam int WIN_TAPS = 9;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        FETCH = 3'd1,
        CALC  = 3'd2,
        WRITE = 3'd3,
        DONE  = 3'd4
    } state_t;

    // Low bit of tap t inside the flattened 72-bit window (t * PIX_W).
    function automatic logic [6:0] win_lo(input logic [3:0] tap);
        return {tap, 3'b000};
    endfunction

endpackage
`default_nettype wire

// File: rtl/sobel_addr_gen.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | sobel_addr_gen                                                     |
// | Row/col/tap counters and read/write address generation.            |
// | Build option: SOBEL_BORDER_ZERO_EN (full-size output, zero border) |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module sobel_addr_gen
    import sobel_pkg::*;
#(
    parameter int IMG_W  = 640,
    parameter int IMG_H  = 480,
    parameter int ADDR_W = 20
) (
    input  logic              clk,
    input  logic              n_rst,
    input  logic              i_load,
    input  logic              i_tap_inc,
    input  logic              i_pix_inc,
    input  logic [ADDR_W-1:0] i_img_base,
    input  logic [ADDR_W-1:0] i_out_base,
    output logic [3:0]        o_tap,
    output logic              o_last_tap,
    output logic              o_last_pix,
    output logic              o_nxt_border,
    output logic [ADDR_W-1:0] o_rd_addr,
    output logic [ADDR_W-1:0] o_wr_addr
);

    localparam int ROW_W = $clog2(IMG_H);
    localparam int COL_W = $clog2(IMG_W);
    localparam logic [ADDR_W-1:0] c_img_w = ADDR_W'(IMG_W);

`ifdef SOBEL_BORDER_ZERO_EN
    localparam logic [ROW_W-1:0]  c_row_last = ROW_W'(IMG_H - 1);
    localparam logic [COL_W-1:0]  c_col_last = COL_W'(IMG_W - 1);
    localparam logic [ADDR_W-1:0] c_out_w    = ADDR_W'(IMG_W);
    localparam logic [ADDR_W-1:0] c_off      = ADDR_W'(1);
`else
    localparam logic [ROW_W-1:0]  c_row_last = ROW_W'(IMG_H - 3);
    localparam logic [COL_W-1:0]  c_col_last = COL_W'(IMG_W - 3);
    localparam logic [ADDR_W-1:0] c_out_w    = ADDR_W'(IMG_W - 2);
    localparam logic [ADDR_W-1:0] c_off      = '0;
`endif

    logic [ADDR_W-1:0] r_img_base;
    logic [ADDR_W-1:0] r_out_base;
    logic [ROW_W-1:0]  r_row;
    logic [COL_W-1:0]  r_col;
    logic [3:0]        r_tap;
    logic [1:0]        r_dr;
    logic [1:0]        r_dc;
    logic [ADDR_W-1:0] w_rd_row;
    logic [ADDR_W-1:0] w_rd_col;

    assign o_tap      = r_tap;
    assign o_last_tap = (r_tap == 4'(WIN_TAPS - 1));
    assign o_last_pix = (r_row == c_row_last) && (r_col == c_col_last);

    // Row/col are output coordinates; the window top-left is shifted up-left
    // by one when the zero border is part of the output image.
    assign w_rd_row  = ADDR_W'(r_row) + ADDR_W'(r_dr) - c_off;
    assign w_rd_col  = ADDR_W'(r_col) + ADDR_W'(r_dc) - c_off;
    assign o_rd_addr = r_img_base + w_rd_row * c_img_w + w_rd_col;
    assign o_wr_addr = r_out_base + ADDR_W'(r_row) * c_out_w + ADDR_W'(r_col);

`ifdef SOBEL_BORDER_ZERO_EN
    logic [ROW_W-1:0] w_nxt_row;
    logic [COL_W-1:0] w_nxt_col;

    assign w_nxt_col    = (r_col == c_col_last) ? '0 : r_col + COL_W'(1);
    assign w_nxt_row    = (r_col == c_col_last) ? r_row + ROW_W'(1) : r_row;
    assign o_nxt_border = (w_nxt_row == '0) || (w_nxt_row == c_row_last) ||
                          (w_nxt_col == '0) || (w_nxt_col == c_col_last);
`else
    assign o_nxt_border = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!n_rst) begin
            r_img_base <= '0;
            r_out_base <= '0;
            r_row      <= '0;
            r_col      <= '0;
            r_tap      <= '0;
            r_dr       <= '0;
            r_dc       <= '0;
        end else if (i_load) begin
            r_img_base <= i_img_base;
            r_out_base <= i_out_base;
            r_row      <= '0;
            r_col      <= '0;
            r_tap      <= '0;
            r_dr       <= '0;
            r_dc       <= '0;
        end else begin
            if (i_tap_inc) begin
                r_tap <= o_last_tap ? 4'd0 : r_tap + 4'd1;
                if (r_dc == 2'd2) begin
                    r_dc <= '0;
                    r_dr <= (r_dr == 2'd2) ? 2'd0 : r_dr + 2'd1;
                end else begin
                    r_dc <= r_dc + 2'd1;
                end
            end
            if (i_pix_inc) begin
                if (r_col == c_col_last) begin
                    r_col <= '0;
                    r_row <= r_row + ROW_W'(1);
                end else begin
                    r_col <= r_col + COL_W'(1);
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/sobel_scan_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | sobel_scan_ctrl                                                    |
// | Window fetch / gradient strobe / write-back sequencer for Sobel.   |
// | Build option: SOBEL_BORDER_ZERO_EN (full-size output, zero border) |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module sobel_scan_ctrl
    import sobel_pkg::*;
#(
    parameter int IMG_W  = 640,
    parameter int IMG_H  = 480,
    parameter int ADDR_W = 20
) (
    input  logic                      clk,
    input  logic                      n_rst,
    input  logic                      start,
    input  logic [ADDR_W-1:0]         img_base,
    input  logic [ADDR_W-1:0]         out_base,
    output logic                      rd_en,
    output logic [ADDR_W-1:0]         rd_addr,
    input  logic                      rd_valid,
    input  logic [PIX_W-1:0]          rd_data,
    output logic [WIN_TAPS*PIX_W-1:0] window,
    output logic                      start_t_grad,
    input  logic [PIX_W-1:0]          g,
    output logic                      wr_en,
    output logic [ADDR_W-1:0]         wr_addr,
    output logic [PIX_W-1:0]          wr_data,
    input  logic                      wr_ack,
    output logic                      busy,
    output logic                      done
);

    state_t            r_state;
    logic              r_armed;
    logic              w_load;
    logic              w_tap_inc;
    logic              w_pix_inc;
    logic [3:0]        w_tap;
    logic              w_last_tap;
    logic              w_last_pix;
    logic              w_nxt_border;
    logic [ADDR_W-1:0] w_rd_addr;
    logic [ADDR_W-1:0] w_wr_addr;

    // r_armed blocks a start that coincides with the reset-release edge.
    assign w_load    = (r_state == IDLE) && start && r_armed;
    assign w_tap_inc = (r_state == FETCH) && rd_en && rd_valid;
    assign w_pix_inc = (r_state == WRITE) && wr_en && wr_ack;

    sobel_addr_gen #(
        .IMG_W  (IMG_W),
        .IMG_H  (IMG_H),
        .ADDR_W (ADDR_W)
    ) u_addr_gen (
        .clk          (clk),
        .n_rst        (n_rst),
        .i_load       (w_load),
        .i_tap_inc    (w_tap_inc),
        .i_pix_inc    (w_pix_inc),
        .i_img_base   (img_base),
        .i_out_base   (out_base),
        .o_tap        (w_tap),
        .o_last_tap   (w_last_tap),
        .o_last_pix   (w_last_pix),
        .o_nxt_border (w_nxt_border),
        .o_rd_addr    (w_rd_addr),
        .o_wr_addr    (w_wr_addr)
    );

    always_ff @(posedge clk) begin
        if (!n_rst) begin
            r_state      <= IDLE;
            r_armed      <= 1'b0;
            rd_en        <= 1'b0;
            rd_addr      <= '0;
            window       <= '0;
            start_t_grad <= 1'b0;
            wr_en        <= 1'b0;
            wr_addr      <= '0;
            wr_data      <= '0;
            busy         <= 1'b0;
            done         <= 1'b0;
        end else begin
            r_armed      <= 1'b1;
            start_t_grad <= 1'b0;
            done         <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_load) begin
                        busy <= 1'b1;
`ifdef SOBEL_BORDER_ZERO_EN
                        // Pixel (0,0) is always border: go straight to write.
                        wr_data <= '0;
                        r_state <= WRITE;
`else
                        r_state <= FETCH;
`endif
                    end
                end
                FETCH: begin
                    if (!rd_en) begin
                        rd_en   <= 1'b1;
                        rd_addr <= w_rd_addr;
                    end else if (rd_valid) begin
                        rd_en <= 1'b0;
                        window[win_lo(w_tap) +: PIX_W] <= rd_data;
                        if (w_last_tap) begin
                            start_t_grad <= 1'b1;
                            r_state      <= CALC;
                        end
                    end
                end
                CALC: begin
                    wr_data <= g;
                    wr_en   <= 1'b1;
                    wr_addr <= w_wr_addr;
                    r_state <= WRITE;
                end
                WRITE: begin
                    // wr_en low here means a border write still has to be raised.
                    if (!wr_en) begin
                        wr_en   <= 1'b1;
                        wr_addr <= w_wr_addr;
                    end else if (wr_ack) begin
                        wr_en <= 1'b0;
                        if (w_last_pix) begin
                            busy    <= 1'b0;
                            done    <= 1'b1;
                            r_state <= DONE;
                        end else if (w_nxt_border) begin
                            wr_data <= '0;
                        end else begin
                            r_state <= FETCH;
                        end
                    end
                end
                DONE: begin
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire
